// File: rtl/alu_arbiter_if.sv
// Request/grant, shared-ALU operand/result and completion signals for alu_arbiter.
// The slave modport is the arbiter's view; master is the requester/ALU side.
interface alu_arbiter_if;
   logic        i_bi_req0;
   logic        i_bi_req1;
   logic [31:0] i_ul_a0;
   logic [31:0] i_ul_b0;
   logic [31:0] i_ul_a1;
   logic [31:0] i_ul_b1;
   logic [2:0]  i_u3_sel0;
   logic [2:0]  i_u3_sel1;
   logic        o_bi_gnt0;
   logic        o_bi_gnt1;
   logic [31:0] o_ul_a;
   logic [31:0] o_ul_b;
   logic [2:0]  o_u3_sel;
   logic [31:0] i_ul_r;
   logic [31:0] o_ul_r;
   logic        o_bi_zflag;
   logic        o_bi_vld;
   logic        o_bi_id;

   modport slave (
      input  i_bi_req0, i_bi_req1, i_ul_a0, i_ul_b0, i_ul_a1, i_ul_b1,
      input  i_u3_sel0, i_u3_sel1, i_ul_r,
      output o_bi_gnt0, o_bi_gnt1, o_ul_a, o_ul_b, o_u3_sel,
      output o_ul_r, o_bi_zflag, o_bi_vld, o_bi_id
   );

   modport master (
      output i_bi_req0, i_bi_req1, i_ul_a0, i_ul_b0, i_ul_a1, i_ul_b1,
      output i_u3_sel0, i_u3_sel1, i_ul_r,
      input  o_bi_gnt0, o_bi_gnt1, o_ul_a, o_ul_b, o_u3_sel,
      input  o_ul_r, o_bi_zflag, o_bi_vld, o_bi_id
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one multi-cycle ALU between two requesters.
// One operation in flight: IDLE -> ISSUE -> WAIT (LAT cycles) -> RESP, all outputs registered.
module alu_arbiter #(
   parameter int unsigned LAT = 1
) (
   input logic          clk,
   input logic          rst,
   alu_arbiter_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        prio_q, prio_d;
   logic        win_q, win_d;
   logic        gnt0_q, gnt0_d;
   logic        gnt1_q, gnt1_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [2:0]  sel_q, sel_d;
   logic [31:0] r_q, r_d;
   logic        z_q, z_d;
   logic        vld_q, vld_d;
   logic        id_q, id_d;

   logic any_req;
   logic win;
   logic last_wait;

   assign any_req   = bus.i_bi_req0 | bus.i_bi_req1;
   // prio_q names the favoured requester when both ask at once
   assign win       = (bus.i_bi_req0 && bus.i_bi_req1) ? prio_q : bus.i_bi_req1;
   assign last_wait = (cnt_q == 4'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         prio_q  <= 1'b0;
         win_q   <= 1'b0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         sel_q   <= 3'd0;
         r_q     <= 32'd0;
         z_q     <= 1'b0;
         vld_q   <= 1'b0;
         id_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prio_q  <= prio_d;
         win_q   <= win_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sel_q   <= sel_d;
         r_q     <= r_d;
         z_q     <= z_d;
         vld_q   <= vld_d;
         id_q    <= id_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (any_req) state_d = StIssue;
         StIssue: state_d = StWait;
         StWait:  if (last_wait) state_d = StResp;
         StResp:  state_d = StIdle;
      endcase
   end

   always_comb begin
      cnt_d  = cnt_q;
      prio_d = prio_q;
      win_d  = win_q;
      gnt0_d = 1'b0;
      gnt1_d = 1'b0;
      a_d    = a_q;
      b_d    = b_q;
      sel_d  = sel_q;
      r_d    = r_q;
      z_d    = z_q;
      vld_d  = 1'b0;
      id_d   = id_q;
      unique case (state_q)
         StIdle: begin
            if (any_req) begin
               win_d  = win;
               gnt0_d = ~win;
               gnt1_d = win;
               a_d    = win ? bus.i_ul_a1 : bus.i_ul_a0;
               b_d    = win ? bus.i_ul_b1 : bus.i_ul_b0;
               sel_d  = win ? bus.i_u3_sel1 : bus.i_u3_sel0;
            end
         end
         StIssue: cnt_d = 4'(LAT);
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (last_wait) begin
               r_d   = bus.i_ul_r;
               z_d   = (bus.i_ul_r == 32'd0);
               id_d  = win_q;
               vld_d = 1'b1;
            end
         end
         StResp: prio_d = ~id_q;
      endcase
   end

   assign bus.o_bi_gnt0  = gnt0_q;
   assign bus.o_bi_gnt1  = gnt1_q;
   assign bus.o_ul_a     = a_q;
   assign bus.o_ul_b     = b_q;
   assign bus.o_u3_sel   = sel_q;
   assign bus.o_ul_r     = r_q;
   assign bus.o_bi_zflag = z_q;
   assign bus.o_bi_vld   = vld_q;
   assign bus.o_bi_id    = id_q;

endmodule
